// File: rtl/fifo_ram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_ram_pkg
// Brief    : Shared types and pointer-wrap helper for the RAM-backed FIFO.
// Revision : 1.0 - initial release
// ============================================================================
package fifo_ram_pkg;

    localparam int C_ADDRBIT = 9;

    typedef logic [C_ADDRBIT-1:0] ptr_t;
    typedef logic [C_ADDRBIT+1:0] cnt_t;
    typedef logic [1:0]           ost_cnt_t;

    // Wraps at an arbitrary depth, so DEPTH need not be a power of two.
    function automatic logic [31:0] ptr_inc(input logic [31:0] i_ptr,
                                            input logic [31:0] i_depth);
        return (i_ptr == i_depth - 32'd1) ? 32'd0 : i_ptr + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_ostg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_ostg
// Brief    : Two-entry first-word-fall-through output stage (head + skid).
// Revision : 1.0 - initial release
// ============================================================================
module fifo_ostg
    import fifo_ram_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_ldat,
    input  logic             i_pop,
    output logic             o_vld,
    output logic [WIDTH-1:0] o_dat,
    output ost_cnt_t         o_cnt,
    output logic             o_pop_acc
);

    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_skid;
    ost_cnt_t         r_cnt;
    logic [WIDTH-1:0] w_head_nxt;
    logic [WIDTH-1:0] w_skid_nxt;
    ost_cnt_t         w_cnt_shift;
    ost_cnt_t         w_cnt_nxt;
    logic             w_pop_acc;

    assign w_pop_acc = i_pop & (r_cnt != 2'd0);

    // Shift on pop first, then the incoming word takes the first free slot.
    always_comb begin
        w_head_nxt  = r_head;
        w_skid_nxt  = r_skid;
        w_cnt_shift = r_cnt - {1'b0, w_pop_acc};
        if (w_pop_acc) begin
            w_head_nxt = r_skid;
        end
        if (i_load) begin
            if (w_cnt_shift == 2'd0) begin
                w_head_nxt = i_ldat;
            end else begin
                w_skid_nxt = i_ldat;
            end
        end
        w_cnt_nxt = w_cnt_shift + {1'b0, i_load};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head <= '0;
            r_skid <= '0;
            r_cnt  <= 2'd0;
        end else if (flush) begin
            r_head <= '0;
            r_skid <= '0;
            r_cnt  <= 2'd0;
        end else begin
            r_head <= w_head_nxt;
            r_skid <= w_skid_nxt;
            r_cnt  <= w_cnt_nxt;
        end
    end

    assign o_vld     = (r_cnt != 2'd0);
    assign o_dat     = r_head;
    assign o_cnt     = r_cnt;
    assign o_pop_acc = w_pop_acc;

endmodule
`default_nettype wire

// File: rtl/fifo_ram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fifo_ram_ctrl
// Brief    : Single-clock FIFO controller driving an external 1-cycle-latency
//            RAM and presenting its contents as an FWFT valid/pop stream.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_ram_ctrl
    import fifo_ram_pkg::*;
#(
    parameter int ADDRBIT = 9,
    parameter int DEPTH   = 512,
    parameter int WIDTH   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               push,
    input  logic [WIDTH-1:0]   pdat,
    output logic               full,
    input  logic               pop,
    output logic               ovld,
    output logic [WIDTH-1:0]   odat,
    output logic [ADDRBIT+1:0] count,
    output logic               ovf,
    output logic               udf,
    output logic [ADDRBIT-1:0] ram_wa,
    output logic               ram_we,
    output logic [WIDTH-1:0]   ram_wdi,
    output logic [ADDRBIT-1:0] ram_ra,
    output logic               ram_re,
    input  logic [WIDTH-1:0]   ram_rdo
);

    localparam logic [ADDRBIT+1:0] C_DEPTH = (ADDRBIT+2)'(DEPTH);

    logic [ADDRBIT-1:0] r_wptr;
    logic [ADDRBIT-1:0] r_rptr;
    logic [ADDRBIT+1:0] r_ram_cnt;
    logic               r_pend;
    logic               r_ovf;
    logic               r_udf;

    logic [ADDRBIT-1:0] w_wptr_inc;
    logic [ADDRBIT-1:0] w_rptr_inc;
    logic               w_full;
    logic               w_we;
    logic               w_re;
    logic               w_ovld;
    logic               w_pop_acc;
    ost_cnt_t           w_ost_cnt;
    logic [2:0]         w_occ;

    assign w_full = (r_ram_cnt == C_DEPTH);
    assign w_we   = push & ~w_full & ~flush & ~rst;

    // Occupancy of the output stage once this cycle's pop and landing word settle.
    assign w_occ = {1'b0, w_ost_cnt} + {2'b0, r_pend} - {2'b0, w_pop_acc};
    assign w_re  = (r_ram_cnt != '0) & (w_occ < 3'd2) & ~flush & ~rst;

    assign w_wptr_inc = ADDRBIT'(ptr_inc(32'(r_wptr), 32'(DEPTH)));
    assign w_rptr_inc = ADDRBIT'(ptr_inc(32'(r_rptr), 32'(DEPTH)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_ram_cnt <= '0;
            r_pend    <= 1'b0;
            r_ovf     <= 1'b0;
            r_udf     <= 1'b0;
        end else if (flush) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_ram_cnt <= '0;
            r_pend    <= 1'b0;
            r_ovf     <= 1'b0;
            r_udf     <= 1'b0;
        end else begin
            if (w_we) begin
                r_wptr <= w_wptr_inc;
            end
            if (w_re) begin
                r_rptr <= w_rptr_inc;
            end
            r_ram_cnt <= r_ram_cnt + (ADDRBIT+2)'(w_we) - (ADDRBIT+2)'(w_re);
            r_pend    <= w_re;
            if (push & w_full) begin
                r_ovf <= 1'b1;
            end
            if (pop & ~w_ovld) begin
                r_udf <= 1'b1;
            end
        end
    end

    fifo_ostg #(
        .WIDTH (WIDTH)
    ) u_ostg (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .i_load    (r_pend),
        .i_ldat    (ram_rdo),
        .i_pop     (pop),
        .o_vld     (w_ovld),
        .o_dat     (odat),
        .o_cnt     (w_ost_cnt),
        .o_pop_acc (w_pop_acc)
    );

    assign full    = w_full;
    assign ovld    = w_ovld;
    assign count   = r_ram_cnt + (ADDRBIT+2)'(r_pend) + (ADDRBIT+2)'(w_ost_cnt);
    assign ovf     = r_ovf;
    assign udf     = r_udf;
    assign ram_wa  = r_wptr;
    assign ram_we  = w_we;
    assign ram_wdi = w_we ? pdat : '0;
    assign ram_ra  = r_rptr;
    assign ram_re  = w_re;

endmodule
`default_nettype wire

// File: tb/tb_fifo_ram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_ram_ctrl
// Brief    : Self-checking bench for fifo_ram_ctrl (DEPTH=512 and DEPTH=5).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_ram_ctrl;

    logic        clk;
    logic        rst, flush, push, pop;
    logic [31:0] pdat;

    logic        full0, ovld0, ovf0, udf0, we0, re0;
    logic [31:0] odat0, wdi0, rdo0;
    logic [10:0] count0;
    logic [8:0]  wa0, ra0;
    logic        full1, ovld1, ovf1, udf1, we1, re1;
    logic [31:0] odat1, wdi1, rdo1;
    logic [4:0]  count1;
    logic [2:0]  wa1, ra1;

    logic [31:0] mem0 [512];
    logic [31:0] mem1 [8];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference: RAM content as a plain queue, in-flight word, output list.
    int          m_depth [2];
    logic [31:0] m_mem   [2][1024];
    int          m_rh [2], m_rn [2], m_on [2], m_wp [2], m_rp [2];
    bit          m_pend [2], m_ovf [2], m_udf [2];
    logic [31:0] m_pdat [2];
    logic [31:0] m_out  [2][2];

    logic        s_we0, s_re0, s_ovld0, s_ovf0, s_udf0, s_full0, s_we1;
    logic [31:0] s_wa0, s_ra0, s_odat0, s_count0, s_wa1;

    fifo_ram_ctrl #(.ADDRBIT(9), .DEPTH(512), .WIDTH(32)) dut0 (
        .clk(clk), .rst(rst), .flush(flush), .push(push), .pdat(pdat), .full(full0),
        .pop(pop), .ovld(ovld0), .odat(odat0), .count(count0), .ovf(ovf0), .udf(udf0),
        .ram_wa(wa0), .ram_we(we0), .ram_wdi(wdi0), .ram_ra(ra0), .ram_re(re0), .ram_rdo(rdo0)
    );

    fifo_ram_ctrl #(.ADDRBIT(3), .DEPTH(5), .WIDTH(32)) dut1 (
        .clk(clk), .rst(rst), .flush(flush), .push(push), .pdat(pdat), .full(full1),
        .pop(pop), .ovld(ovld1), .odat(odat1), .count(count1), .ovf(ovf1), .udf(udf1),
        .ram_wa(wa1), .ram_we(we1), .ram_wdi(wdi1), .ram_ra(ra1), .ram_re(re1), .ram_rdo(rdo1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (we0) mem0[wa0] <= wdi0;
        if (re0) rdo0 <= mem0[ra0];
        if (we1) mem1[wa1] <= wdi1;
        if (re1) rdo1 <= mem1[ra1];
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1);
    end

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_rh[k] = 0; m_rn[k] = 0; m_on[k] = 0; m_wp[k] = 0; m_rp[k] = 0;
            m_pend[k] = 1'b0; m_ovf[k] = 1'b0; m_udf[k] = 1'b0;
        end
    endtask

    task automatic model_cycle(input int k, input bit i_push, input logic [31:0] i_dat,
                               input bit i_pop, input bit i_flush);
        string       nm;
        logic        a_full, a_ovld, a_ovf, a_udf, a_we, a_re;
        logic [31:0] a_cnt, a_wa, a_ra, a_odat, a_wdi;
        bit          e_full, e_we, e_re, pop_acc;
        int          e_cnt;
        if (k == 0) begin
            nm = "d512"; a_full = full0; a_ovld = ovld0; a_ovf = ovf0; a_udf = udf0;
            a_we = we0; a_re = re0; a_cnt = 32'(count0); a_wa = 32'(wa0); a_ra = 32'(ra0);
            a_odat = odat0; a_wdi = wdi0;
        end else begin
            nm = "d5"; a_full = full1; a_ovld = ovld1; a_ovf = ovf1; a_udf = udf1;
            a_we = we1; a_re = re1; a_cnt = 32'(count1); a_wa = 32'(wa1); a_ra = 32'(ra1);
            a_odat = odat1; a_wdi = wdi1;
        end
        e_full  = (m_rn[k] == m_depth[k]);
        pop_acc = i_pop && (m_on[k] > 0);
        e_we    = i_push && !e_full && !i_flush;
        e_re    = (m_rn[k] > 0) && (m_on[k] - int'(pop_acc) + int'(m_pend[k]) < 2) && !i_flush;
        e_cnt   = m_rn[k] + int'(m_pend[k]) + m_on[k];

        n_tests++;
        if (a_full !== e_full) begin n_fail++; $display("FAIL %s full: got %0b exp %0b", nm, a_full, e_full); end
        n_tests++;
        if (a_ovld !== (m_on[k] > 0)) begin n_fail++; $display("FAIL %s ovld: got %0b exp %0b", nm, a_ovld, m_on[k] > 0); end
        n_tests++;
        if (a_cnt !== 32'(e_cnt)) begin n_fail++; $display("FAIL %s count: got %0d exp %0d", nm, a_cnt, e_cnt); end
        n_tests++;
        if (a_ovf !== m_ovf[k]) begin n_fail++; $display("FAIL %s ovf: got %0b exp %0b", nm, a_ovf, m_ovf[k]); end
        n_tests++;
        if (a_udf !== m_udf[k]) begin n_fail++; $display("FAIL %s udf: got %0b exp %0b", nm, a_udf, m_udf[k]); end
        n_tests++;
        if (a_we !== e_we) begin n_fail++; $display("FAIL %s ram_we: got %0b exp %0b", nm, a_we, e_we); end
        n_tests++;
        if (a_re !== e_re) begin n_fail++; $display("FAIL %s ram_re: got %0b exp %0b", nm, a_re, e_re); end
        if (e_we) begin
            n_tests++;
            if (a_wa !== 32'(m_wp[k])) begin n_fail++; $display("FAIL %s ram_wa: got %0d exp %0d", nm, a_wa, m_wp[k]); end
            n_tests++;
            if (a_wdi !== i_dat) begin n_fail++; $display("FAIL %s ram_wdi: got %h exp %h", nm, a_wdi, i_dat); end
        end
        if (e_re) begin
            n_tests++;
            if (a_ra !== 32'(m_rp[k])) begin n_fail++; $display("FAIL %s ram_ra: got %0d exp %0d", nm, a_ra, m_rp[k]); end
        end
        if (m_on[k] > 0) begin
            n_tests++;
            if (a_odat !== m_out[k][0]) begin n_fail++; $display("FAIL %s odat: got %h exp %h", nm, a_odat, m_out[k][0]); end
        end
        n_tests++;
        if (a_we === 1'b1 && a_re === 1'b1 && a_wa === a_ra) begin
            n_fail++; $display("FAIL %s collision: got wa=ra=%0d exp distinct", nm, a_wa);
        end

        if (i_flush) begin
            m_rh[k] = 0; m_rn[k] = 0; m_on[k] = 0; m_wp[k] = 0; m_rp[k] = 0;
            m_pend[k] = 1'b0; m_ovf[k] = 1'b0; m_udf[k] = 1'b0;
        end else begin
            if (i_pop && m_on[k] == 0) m_udf[k] = 1'b1;
            if (i_push && e_full) m_ovf[k] = 1'b1;
            if (pop_acc) begin
                m_out[k][0] = m_out[k][1];
                m_on[k] = m_on[k] - 1;
            end
            if (m_pend[k]) begin
                m_out[k][m_on[k]] = m_pdat[k];
                m_on[k] = m_on[k] + 1;
            end
            if (e_re) begin
                m_pdat[k] = m_mem[k][m_rh[k]];
                m_rh[k] = (m_rh[k] + 1) % 1024;
                m_rn[k] = m_rn[k] - 1;
                m_rp[k] = (m_rp[k] + 1) % m_depth[k];
            end
            if (e_we) begin
                m_mem[k][(m_rh[k] + m_rn[k]) % 1024] = i_dat;
                m_rn[k] = m_rn[k] + 1;
                m_wp[k] = (m_wp[k] + 1) % m_depth[k];
            end
            m_pend[k] = e_re;
        end
    endtask

    // Entered at posedge+1; samples at the falling edge, returns at posedge+1.
    task automatic tick(input bit i_push, input logic [31:0] i_dat, input bit i_pop, input bit i_flush);
        push = i_push; pdat = i_dat; pop = i_pop; flush = i_flush;
        #4;
        s_we0 = we0; s_re0 = re0; s_ovld0 = ovld0; s_ovf0 = ovf0; s_udf0 = udf0; s_full0 = full0;
        s_wa0 = 32'(wa0); s_ra0 = 32'(ra0); s_odat0 = odat0; s_count0 = 32'(count0);
        s_we1 = we1; s_wa1 = 32'(wa1);
        for (int k = 0; k < 2; k++) model_cycle(k, i_push, i_dat, i_pop, i_flush);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        n_tests++; if (count0 !== 11'd0) begin n_fail++; $display("FAIL rst_count: got %0d exp 0", count0); end
        n_tests++; if (ovld0 !== 1'b0) begin n_fail++; $display("FAIL rst_ovld: got %0b exp 0", ovld0); end
        n_tests++; if (odat0 !== 32'd0) begin n_fail++; $display("FAIL rst_odat: got %h exp 0", odat0); end
        n_tests++; if (full0 !== 1'b0) begin n_fail++; $display("FAIL rst_full: got %0b exp 0", full0); end
        n_tests++; if ({ovf0, udf0} !== 2'b00) begin n_fail++; $display("FAIL rst_flags: got %b exp 00", {ovf0, udf0}); end
        n_tests++; if ({we0, re0} !== 2'b00) begin n_fail++; $display("FAIL rst_en: got %b exp 00", {we0, re0}); end
        n_tests++; if ({wa0, ra0} !== 18'd0) begin n_fail++; $display("FAIL rst_addr: got %h exp 0", {wa0, ra0}); end
        n_tests++; if (wdi0 !== 32'd0) begin n_fail++; $display("FAIL rst_wdi: got %h exp 0", wdi0); end
        rst = 1'b0;
    endtask

    task automatic test_single();
        tick(1'b1, 32'hA5A5_0001, 1'b0, 1'b0);
        n_tests++; if (s_we0 !== 1'b1 || s_wa0 !== 32'd0) begin n_fail++; $display("FAIL single_we: got we=%0b wa=%0d exp 1/0", s_we0, s_wa0); end
        tick(1'b0, 32'd0, 1'b0, 1'b0);
        n_tests++; if (s_re0 !== 1'b1 || s_ra0 !== 32'd0) begin n_fail++; $display("FAIL single_re: got re=%0b ra=%0d exp 1/0", s_re0, s_ra0); end
        tick(1'b0, 32'd0, 1'b0, 1'b0);
        n_tests++; if (s_ovld0 !== 1'b0) begin n_fail++; $display("FAIL single_early: got ovld=%0b exp 0", s_ovld0); end
        tick(1'b0, 32'd0, 1'b1, 1'b0);
        n_tests++; if (s_ovld0 !== 1'b1 || s_odat0 !== 32'hA5A5_0001) begin n_fail++; $display("FAIL single_data: got ovld=%0b odat=%h exp 1/a5a50001", s_ovld0, s_odat0); end
        tick(1'b0, 32'd0, 1'b0, 1'b0);
        n_tests++; if (s_ovld0 !== 1'b0 || s_count0 !== 32'd0) begin n_fail++; $display("FAIL single_pop: got ovld=%0b count=%0d exp 0/0", s_ovld0, s_count0); end
    endtask

    task automatic test_fill();
        int got = 0;
        int cyc = 0;
        for (int i = 0; i < 514; i++) tick(1'b1, 32'(i), 1'b0, 1'b0);
        tick(1'b1, 32'd514, 1'b0, 1'b0);
        n_tests++; if (s_full0 !== 1'b1 || s_count0 !== 32'd514) begin n_fail++; $display("FAIL fill_full: got full=%0b count=%0d exp 1/514", s_full0, s_count0); end
        tick(1'b0, 32'd0, 1'b0, 1'b0);
        n_tests++; if (s_ovf0 !== 1'b1 || s_count0 !== 32'd514) begin n_fail++; $display("FAIL fill_ovf: got ovf=%0b count=%0d exp 1/514", s_ovf0, s_count0); end
        while (got < 514 && cyc < 2000) begin
            if (ovld0 === 1'b1) begin
                n_tests++; if (odat0 !== 32'(got)) begin n_fail++; $display("FAIL drain_data: got %0d exp %0d", odat0, got); end
                got++;
                tick(1'b0, 32'd0, 1'b1, 1'b0);
            end else begin
                tick(1'b0, 32'd0, 1'b0, 1'b0);
            end
            cyc++;
        end
        n_tests++; if (got != 514) begin n_fail++; $display("FAIL drain_done: got %0d words exp 514", got); end
    endtask

    task automatic test_wrap();
        int  sent = 0, got = 0, nw = 0, cyc = 0;
        bit  do_push, do_pop;
        tick(1'b0, 32'd0, 1'b0, 1'b1);
        while (got < 20 && cyc < 600) begin
            do_push = (sent < 20) && (full1 === 1'b0) && ($urandom % 2 == 0);
            do_pop  = (ovld1 === 1'b1) && ($urandom % 3 != 0);
            if (do_pop) begin
                n_tests++; if (odat1 !== 32'h5000 + 32'(got)) begin n_fail++; $display("FAIL wrap_data: got %h exp %h", odat1, 32'h5000 + 32'(got)); end
                got++;
            end
            tick(do_push, 32'h5000 + 32'(sent), do_pop, 1'b0);
            if (do_push) sent++;
            if (s_we1 === 1'b1) begin
                n_tests++; if (s_wa1 !== 32'(nw % 5)) begin n_fail++; $display("FAIL wrap_wa: got %0d exp %0d", s_wa1, nw % 5); end
                nw++;
            end
            cyc++;
        end
        n_tests++; if (got != 20) begin n_fail++; $display("FAIL wrap_done: got %0d words exp 20", got); end
    endtask

    task automatic test_stream();
        int seq = 0, exp_d = 0, guard = 0;
        tick(1'b0, 32'd0, 1'b0, 1'b1);
        while (ovld0 !== 1'b1 && guard < 10) begin
            tick(1'b1, 32'h8000_0000 + 32'(seq), 1'b0, 1'b0);
            seq++; guard++;
        end
        n_tests++; if (ovld0 !== 1'b1) begin n_fail++; $display("FAIL stream_start: got ovld=%0b exp 1", ovld0); end
        for (int i = 0; i < 1000; i++) begin
            n_tests++; if (ovld0 !== 1'b1 || odat0 !== 32'h8000_0000 + 32'(exp_d)) begin
                n_fail++; $display("FAIL stream_data: got ovld=%0b odat=%h exp 1/%h", ovld0, odat0, 32'h8000_0000 + 32'(exp_d));
            end
            exp_d++;
            tick(1'b1, 32'h8000_0000 + 32'(seq), 1'b1, 1'b0);
            seq++;
            n_tests++; if (s_count0 !== 32'd3) begin n_fail++; $display("FAIL stream_count: got %0d exp 3", s_count0); end
        end
    endtask

    task automatic test_underflow();
        tick(1'b0, 32'd0, 1'b0, 1'b1);
        tick(1'b0, 32'd0, 1'b1, 1'b0);
        tick(1'b0, 32'd0, 1'b0, 1'b0);
        n_tests++; if (s_udf0 !== 1'b1 || s_count0 !== 32'd0) begin n_fail++; $display("FAIL udf: got udf=%0b count=%0d exp 1/0", s_udf0, s_count0); end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 8; i++) tick(1'b1, 32'h7000 + 32'(i), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) tick(1'b0, 32'd0, 1'b0, 1'b0);
        tick(1'b0, 32'd0, 1'b1, 1'b0);
        tick(1'b1, 32'hDEAD_0000, 1'b0, 1'b1);
        n_tests++; if (s_count0 !== 32'd7) begin n_fail++; $display("FAIL flush_pre: got count=%0d exp 7", s_count0); end
        n_tests++; if ({s_we0, s_re0} !== 2'b00) begin n_fail++; $display("FAIL flush_en: got %b exp 00", {s_we0, s_re0}); end
        tick(1'b0, 32'd0, 1'b0, 1'b0);
        n_tests++; if (s_count0 !== 32'd0 || s_ovld0 !== 1'b0) begin n_fail++; $display("FAIL flush_post: got count=%0d ovld=%0b exp 0/0", s_count0, s_ovld0); end
        n_tests++; if ({s_ovf0, s_udf0} !== 2'b00) begin n_fail++; $display("FAIL flush_flags: got %b exp 00", {s_ovf0, s_udf0}); end
        tick(1'b0, 32'd0, 1'b0, 1'b0);
        n_tests++; if (s_ovld0 !== 1'b0) begin n_fail++; $display("FAIL flush_stale: got ovld=%0b exp 0", s_ovld0); end
    endtask

    task automatic test_async_reset();
        tick(1'b0, 32'd0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) tick(1'b1, 32'h9000 + 32'(i), ovld0 === 1'b1, 1'b0);
        push = 1'b1; pop = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        n_tests++; if (count0 !== 11'd0 || ovld0 !== 1'b0 || odat0 !== 32'd0) begin
            n_fail++; $display("FAIL arst_out: got count=%0d ovld=%0b odat=%h exp 0/0/0", count0, ovld0, odat0);
        end
        n_tests++; if ({we0, re0, full0, ovf0, udf0} !== 5'd0) begin n_fail++; $display("FAIL arst_ctl: got %b exp 00000", {we0, re0, full0, ovf0, udf0}); end
        @(posedge clk);
        #2;
        rst = 1'b0; push = 1'b0; pop = 1'b0;
        model_reset();
        tick(1'b1, 32'hBEEF_0001, 1'b0, 1'b0);
        tick(1'b0, 32'd0, 1'b0, 1'b0);
        tick(1'b0, 32'd0, 1'b0, 1'b0);
        tick(1'b0, 32'd0, 1'b0, 1'b0);
        n_tests++; if (s_ovld0 !== 1'b1 || s_odat0 !== 32'hBEEF_0001) begin n_fail++; $display("FAIL arst_resume: got ovld=%0b odat=%h exp 1/beef0001", s_ovld0, s_odat0); end
    endtask

    initial begin
        m_depth[0] = 512;
        m_depth[1] = 5;
        rst = 1'b1; flush = 1'b0; push = 1'b0; pop = 1'b0; pdat = 32'd0;
        model_reset();
        test_reset();
        test_single();
        test_fill();
        test_wrap();
        test_stream();
        test_underflow();
        test_flush();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo_ram_ctrl.md
Name: fifo_ram_ctrl

Overview:
Single-clock FIFO controller that owns one external RAM instance with a write port and a registered read port (1-cycle read latency). It generates the RAM's write and read controls and turns the raw RAM read data into a first-word-fall-through (FWFT) valid/pop stream. It never issues a same-address read and write in one cycle.

Parameters:
ADDRBIT, 9, RAM address width.
DEPTH, 512, RAM entries; 2 <= DEPTH <= 2**ADDRBIT; need not be a power of two.
WIDTH, 32, data width.

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
flush  in  1  synchronous clear of all FIFO contents
push  in  1  write request
pdat  in  WIDTH  write data
full  out  1  RAM full (ram_cnt == DEPTH)
pop  in  1  consume head word
ovld  out  1  head word valid
odat  out  WIDTH  head word
count  out  ADDRBIT+2  total words held (RAM + in-flight + output stage)
ovf  out  1  sticky: push while full
udf  out  1  sticky: pop while !ovld
ram_wa  out  ADDRBIT  RAM write address
ram_we  out  1  RAM write enable
ram_wdi  out  WIDTH  RAM write data
ram_ra  out  ADDRBIT  RAM read address
ram_re  out  1  RAM read enable
ram_rdo  in  WIDTH  RAM read data, valid the cycle after ram_re
The RAM's test and mask inputs are tied to 0 by the integrator.

Behaviour:
- Reset (rst=1, async): wptr=rptr=0, ram_cnt=0, pend=0, output stage empty. Outputs: full=0, ovld=0, odat=0, count=0, ovf=0, udf=0, ram_we=0, ram_re=0, ram_wa=0, ram_ra=0, ram_wdi=0.
- Write: ram_we = push & !full & !flush, combinational. ram_wa = wptr, ram_wdi = pdat. The write takes effect at the edge, and wptr advances, wrapping from DEPTH-1 to 0.
- Read issue: ram_re = (ram_cnt > 0) & (ost_cnt - pop_acc + pend < 2) & !flush, combinational. ram_ra = rptr; rptr advances with wrap. pend <= ram_re.
  - pend=1 means ram_rdo is valid this cycle, and the data is written into the output stage at the edge.
- Collision rule: ram_re requires ram_cnt > 0, and ram_we requires ram_cnt < DEPTH. As a result, wa == ra with both enables high never happens.
  - The bench asserts this every cycle.
- ram_cnt update: += we, -= re, both applied in the same cycle.
- Output stage (sub-module fifo_ostg):
  - 2-entry register FIFO: head register plus skid register.
  - ost_cnt is 0..2; ovld = (ost_cnt > 0); odat = head register.
  - pop_acc = pop & ovld. On pop_acc, the skid entry moves to head.
  - An incoming ram_rdo word fills the first free slot after the shift.
  - Simultaneous pop and load are both honoured, and order is preserved.
- Latency (empty FIFO): push in cycle 0 -> ram_re in cycle 1 -> ram_rdo valid in cycle 2 -> ovld=1 in cycle 3.
- Throughput: 1 word/cycle sustained with continuous push and pop.
- count = ram_cnt + pend + ost_cnt. Maximum is DEPTH+2.
- full depends only on ram_cnt. push & pop while full: pop is accepted and the push is rejected (ovf set), because RAM space frees only when the next read issues.
- ovf/udf: set on the violating cycle and visible the next cycle. The rejected request has no other effect. Cleared only by rst or flush.
- flush (synchronous, overrides push/pop):
  - At the edge, return all state, ovf and udf to reset values.
  - Any in-flight ram_rdo (pend=1) is discarded.
  - ram_we and ram_re are 0 during the flush cycle.
- Reset mid-operation: immediate return to reset state. RAM contents are don't-care and are never read without a prior write.

Decomposition:
- Package fifo_ram_pkg: typedefs for pointer (ADDRBIT) and count (ADDRBIT+2); function ptr_inc(ptr, DEPTH) implementing the wrap.
- Sub-module fifo_ostg: 2-entry FWFT output register stage with load/pop, ost_cnt output.
- Top level: pointers, ram_cnt, pend, sticky flags.

Test Plan:
- Single word: DEPTH=512, push pdat=32'hA5A5_0001 in cycle 0 -> ram_we/ram_wa=0 in cycle 0; ram_re/ram_ra=0 in cycle 1; ovld=1, odat=32'hA5A5_0001 in cycle 3; pop -> ovld=0, count=0.
- Fill: 514 pushes, no pop -> full=1 after 514th accepted push, count=514; 515th push -> ovf=1, count unchanged. Then drain 514 pops -> data 0..513 in order.
- Wrap with DEPTH=5 (non-power-of-two): 20 words with random push/pop gaps -> wptr/rptr sequence 0,1,2,3,4,0; output order exact.
- Streaming: push and pop every cycle for 1000 cycles after first ovld -> no bubble, count constant at 3, no collision assertion fires.
- Pop on empty -> udf=1 next cycle, count stays 0. Flush while count=7 with pend=1 -> next cycle count=0, ovld=0, ovf=udf=0, stale ram_rdo not loaded.
- Async rst asserted mid-stream between edges -> outputs 0 immediately. After release, a new push appears at odat in cycle 3.
